// File: rtl/mem_port_arbiter.sv
// Shared memory-port arbiter for instruction-fetch and data-memory requesters.
// One transaction in flight at a time, DM/IF alternation, and a bounded wait on the memory ack.
module mem_port_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_valid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_if_o,
  output logic              stall_mem_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              owner_dm;
  logic              last_dm;
  logic              we_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic [7:0]        wait_cnt;

  logic              any_req;
  logic              grant_dm;
  logic              timeout;

  assign any_req  = if_req_i | dm_req_i;
  // DM normally wins; IF takes the port right after a DM completion so it cannot starve.
  assign grant_dm = dm_req_i & ~(last_dm & if_req_i);
  // Fires in the WAIT_LIMIT-th BUSY cycle; an ack in that same cycle still wins.
  assign timeout  = (wait_cnt == 8'(WAIT_LIMIT - 1)) & ~mem_ack_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_req) state_nxt = ST_BUSY;
      ST_BUSY: if (mem_ack_i || timeout) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    if_valid_o = 1'b0;
    dm_valid_o = 1'b0;
    err_o      = 1'b0;
    case (state)
      ST_BUSY: begin
        mem_req_o = 1'b1;
        mem_we_o  = we_q;
      end
      ST_DONE: begin
        if_valid_o = ~owner_dm;
        dm_valid_o = owner_dm;
        err_o      = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_dm   <= 1'b0;
      last_dm    <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner_dm <= grant_dm;
            addr_q   <= grant_dm ? dm_addr_i : if_addr_i;
            we_q     <= grant_dm & dm_we_i;
            wdata_q  <= grant_dm ? dm_wdata_i : '0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
          end
        end
        ST_BUSY: begin
          if (mem_ack_i) begin
            if (owner_dm) dm_rdata_q <= mem_rdata_i;
            else          if_rdata_q <= mem_rdata_i;
            err_q   <= 1'b0;
            last_dm <= owner_dm;
          end else if (timeout) begin
            if (owner_dm) dm_rdata_q <= '0;
            else          if_rdata_q <= '0;
            err_q   <= 1'b1;
            last_dm <= owner_dm;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign stall_if_o  = if_req_i & ~if_valid_o;
  assign stall_mem_o = dm_req_i & ~dm_valid_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned WL = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_valid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_valid_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_if_o;
  logic        stall_mem_o;
  logic        err_o;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic        exp_dm;
  logic        m_active, m_own_dm, m_last_dm, m_to, m_we, m_dm_known;
  logic        if_pend, dm_pend, in_busy, at_done;
  int          m_g, m_d, m_lat, m_free;
  logic [31:0] m_addr, m_wdata, m_rd, m_if_rd, m_dm_rd;

  mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .WAIT_LIMIT(WL)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_valid_o(dm_valid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b1; if_req_i = 1'b0; if_addr_i = '0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    dm_addr_i = '0; dm_wdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    step; step;

    // reset state, stall stays combinational during reset
    chk("rst_mem", {mem_req_o, mem_we_o}, 2'b00);
    chk("rst_flags", {if_valid_o, dm_valid_o, err_o}, 3'b000);
    chk("rst_rdata", {if_rdata_o, dm_rdata_o}, 64'd0);
    chk("rst_addr_wdata", {mem_addr_o, mem_wdata_o}, 64'd0);
    if_req_i = 1'b1; dm_req_i = 1'b1; #1;
    chk("rst_stall", {stall_if_o, stall_mem_o}, 2'b11);
    if_req_i = 1'b0; dm_req_i = 1'b0;
    rst_i = 1'b0;

    // ack outside BUSY is ignored
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0BAD;
    step;
    mem_ack_i = 1'b0;
    chk("spur_ack", {mem_req_o, if_valid_o, dm_valid_o, err_o}, 4'b0000);
    chk("spur_rdata", {if_rdata_o, dm_rdata_o}, 64'd0);

    // single fetch
    if_req_i = 1'b1; if_addr_i = 32'h40; #1;
    chk("f_stall_n", stall_if_o, 1'b1);
    chk("f_req_n", mem_req_o, 1'b0);
    step;
    chk("f_req_n1", mem_req_o, 1'b1);
    chk("f_addr", mem_addr_o, 32'h40);
    chk("f_we", mem_we_o, 1'b0);
    chk("f_stall_n1", stall_if_o, 1'b1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h8C220004;
    step;
    mem_ack_i = 1'b0;
    chk("f_valid", {if_valid_o, dm_valid_o, err_o}, 3'b100);
    chk("f_rdata", if_rdata_o, 32'h8C220004);
    chk("f_stall_n2", stall_if_o, 1'b0);
    chk("f_req_n2", mem_req_o, 1'b0);
    if_req_i = 1'b0;
    step;
    chk("f_valid_once", if_valid_o, 1'b0);

    // simultaneous requests from reset: DM first, then alternation
    rst_i = 1'b1; step; rst_i = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h10; dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h200;
    for (int k = 0; k < 4; k++) begin
      exp_dm = (k % 2 == 0);
      step;
      chk("alt_addr", mem_addr_o, exp_dm ? 32'h200 : 32'h10);
      mem_ack_i = 1'b1; mem_rdata_i = 32'hA0000000 + k;
      step;
      mem_ack_i = 1'b0;
      chk("alt_valid", {if_valid_o, dm_valid_o}, exp_dm ? 2'b01 : 2'b10);
      chk("alt_rdata", exp_dm ? dm_rdata_o : if_rdata_o, 32'hA0000000 + k);
      if (k == 3) begin if_req_i = 1'b0; dm_req_i = 1'b0; end
      step;
    end

    // DM write, ack in the third BUSY cycle
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h8; dm_wdata_i = 32'hDEADBEEF;
    step;
    for (int k = 1; k <= 3; k++) begin
      chk("w_busy", {mem_req_o, mem_we_o}, 2'b11);
      chk("w_addr", mem_addr_o, 32'h8);
      chk("w_wdata", mem_wdata_o, 32'hDEADBEEF);
      if (k == 3) mem_ack_i = 1'b1;
      step;
    end
    mem_ack_i = 1'b0;
    chk("w_done", {if_valid_o, dm_valid_o, err_o}, 3'b010);
    chk("w_port_off", {mem_req_o, mem_we_o}, 2'b00);
    dm_req_i = 1'b0; dm_we_i = 1'b0;
    step;
    chk("w_once", dm_valid_o, 1'b0);

    // timeout with no ack
    if_req_i = 1'b1; if_addr_i = 32'h300; mem_rdata_i = 32'h5555;
    step;
    for (int k = 1; k <= 4; k++) begin
      chk("to_busy", mem_req_o, 1'b1);
      chk("to_quiet", {if_valid_o, err_o}, 2'b00);
      step;
    end
    chk("to_done", {if_valid_o, dm_valid_o, err_o}, 3'b101);
    chk("to_rdata", if_rdata_o, 32'h0);
    if_req_i = 1'b0;
    step;
    chk("to_idle", {mem_req_o, if_valid_o, err_o}, 3'b000);

    // ack in the limit cycle wins
    if_req_i = 1'b1; if_addr_i = 32'h304;
    step;
    for (int k = 1; k <= 4; k++) begin
      chk("ak_busy", mem_req_o, 1'b1);
      if (k == 4) begin mem_ack_i = 1'b1; mem_rdata_i = 32'h1234; end
      step;
    end
    mem_ack_i = 1'b0;
    chk("ak_done", {if_valid_o, dm_valid_o, err_o}, 3'b100);
    chk("ak_rdata", if_rdata_o, 32'h1234);
    if_req_i = 1'b0;
    step;

    // granted request withdrawn still completes
    if_req_i = 1'b1; if_addr_i = 32'h44;
    step;
    if_req_i = 1'b0;
    step;
    chk("wd_busy", mem_req_o, 1'b1);
    chk("wd_addr", mem_addr_o, 32'h44);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h77;
    step;
    mem_ack_i = 1'b0;
    chk("wd_done", {if_valid_o, if_rdata_o}, {1'b1, 32'h77});
    step;

    // ungranted request withdrawn is dropped
    dm_req_i = 1'b1; dm_addr_i = 32'h210;
    step;
    if_req_i = 1'b1; if_addr_i = 32'h48;
    step;
    if_req_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h99;
    step;
    mem_ack_i = 1'b0;
    chk("ug_dm_done", dm_valid_o, 1'b1);
    dm_req_i = 1'b0;
    step; step;
    chk("ug_dropped", {mem_req_o, if_valid_o}, 2'b00);

    // reset in the second BUSY cycle, request re-presented afterwards
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h2C0;
    step;
    chk("rb_busy1", mem_req_o, 1'b1);
    step;
    chk("rb_busy2", mem_req_o, 1'b1);
    rst_i = 1'b1;
    step;
    rst_i = 1'b0;
    chk("rb_drop", {mem_req_o, if_valid_o, dm_valid_o, err_o}, 4'b0000);
    chk("rb_addr", mem_addr_o, 32'h0);
    chk("rb_stall", stall_mem_o, 1'b1);
    step;
    chk("rb_re_busy", mem_req_o, 1'b1);
    chk("rb_re_addr", mem_addr_o, 32'h2C0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE0001;
    step;
    mem_ack_i = 1'b0;
    chk("rb_re_done", {if_valid_o, dm_valid_o, err_o}, 3'b010);
    chk("rb_re_rdata", dm_rdata_o, 32'hCAFE0001);
    dm_req_i = 1'b0;
    step;

    // randomized traffic against the transaction-level model
    rst_i = 1'b1; if_req_i = 1'b0; dm_req_i = 1'b0; mem_ack_i = 1'b0;
    step;
    rst_i = 1'b0;
    m_active = 1'b0; m_last_dm = 1'b0; m_free = 0; m_if_rd = '0; m_dm_rd = '0;
    m_dm_known = 1'b1; if_pend = 1'b0; dm_pend = 1'b0; m_own_dm = 1'b0; m_to = 1'b0;
    m_we = 1'b0; m_g = 0; m_d = 0; m_lat = 0; m_addr = '0; m_wdata = '0; m_rd = '0;
    for (int t = 0; t < 2500; t++) begin
      in_busy = m_active && t > m_g && t <= m_g + m_d;
      at_done = m_active && t == m_g + m_d + 1;
      if (at_done) begin
        if (m_own_dm) begin
          m_dm_known = !m_we;
          if (!m_we) m_dm_rd = m_to ? 32'h0 : m_rd;
        end else begin
          m_if_rd = m_to ? 32'h0 : m_rd;
        end
      end
      chk("r_mem_req", mem_req_o, in_busy);
      chk("r_mem_we", mem_we_o, in_busy && m_we);
      chk("r_valid", {if_valid_o, dm_valid_o, err_o},
          {at_done && !m_own_dm, at_done && m_own_dm, at_done && m_to});
      chk("r_if_rdata", if_rdata_o, m_if_rd);
      if (m_dm_known) chk("r_dm_rdata", dm_rdata_o, m_dm_rd);
      chk("r_stall", {stall_if_o, stall_mem_o},
          {if_req_i && !(at_done && !m_own_dm), dm_req_i && !(at_done && m_own_dm)});
      if (in_busy) begin
        chk("r_addr", mem_addr_o, m_addr);
        if (m_we) chk("r_wdata", mem_wdata_o, m_wdata);
      end
      if (at_done) begin
        m_active = 1'b0; m_last_dm = m_own_dm; m_free = t + 1;
        if (m_own_dm) dm_pend = 1'b0; else if_pend = 1'b0;
      end
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1'b1; if_addr_i = $urandom;
      end
      if (!dm_pend && $urandom_range(0, 2) == 0) begin
        dm_pend = 1'b1; dm_we_i = 1'($urandom_range(0, 1)); dm_addr_i = $urandom; dm_wdata_i = $urandom;
      end
      if_req_i = if_pend; dm_req_i = dm_pend;
      if (!m_active && t >= m_free && (if_pend || dm_pend)) begin
        m_own_dm = dm_pend && !(m_last_dm && if_pend);
        m_g      = t;
        m_lat    = int'($urandom_range(1, WL + 2));
        m_to     = m_lat > int'(WL);
        m_d      = m_to ? int'(WL) : m_lat;
        m_addr   = m_own_dm ? dm_addr_i : if_addr_i;
        m_we     = m_own_dm && dm_we_i;
        m_wdata  = dm_wdata_i;
        m_active = 1'b1;
      end
      mem_rdata_i = $urandom;
      in_busy = m_active && t > m_g && t <= m_g + m_d;
      if (in_busy) mem_ack_i = !m_to && t == m_g + m_lat;
      else         mem_ack_i = ($urandom_range(0, 3) == 0);
      if (in_busy && mem_ack_i) m_rd = mem_rdata_i;
      step;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
